// File: rtl/alarm_timer_pkg.sv
// Shared register map, bit positions and address-width helper for alarm_timer_multi.
// Optional tick prescaler is enabled by defining ALARM_TIMER_PRESCALER_EN.
package alarm_timer_pkg;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;
  localparam logic [2:0] REG_PENDING  = 3'd6;
  localparam logic [2:0] REG_RESERVED = 3'd7;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // address = {channel, reg[2:0]}
  function automatic int addr_w(input int num_ch);
    return $clog2(num_ch) + 3;
  endfunction

endpackage

// File: rtl/alarm_timer_channel.sv
// One timer channel: down-counter, period, snapshot, control bits, sticky TO and irq.
// Counting and timeout detection advance on tick; register writes act every clk.
module alarm_timer_channel
  import alarm_timer_pkg::*;
#(
  parameter int                   COUNTER_W = 32,
  parameter logic [COUNTER_W-1:0] RESET_VAL = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        wr_en,
  input  logic [2:0]  reg_sel,
  input  logic [15:0] writedata,
  output logic [15:0] rd_data,
  output logic        irq
);

  logic [COUNTER_W-1:0] cnt;
  logic [COUNTER_W-1:0] period;
  logic [COUNTER_W-1:0] snap;
  logic [COUNTER_W-1:0] cnt_step;
  logic [3:0]           ctrl;
  logic                 run;
  logic                 to;
  logic                 zero_q;
  logic                 reload_pend;
  logic                 wr_status;
  logic                 wr_ctrl;
  logic                 wr_per_l;
  logic                 wr_per_h;
  logic                 wr_period;
  logic                 wr_snap;
  logic                 start;
  logic                 to_edge;

  assign wr_status = wr_en && (reg_sel == REG_STATUS);
  assign wr_ctrl   = wr_en && (reg_sel == REG_CONTROL);
  assign wr_per_l  = wr_en && (reg_sel == REG_PERIOD_L);
  assign wr_per_h  = wr_en && (reg_sel == REG_PERIOD_H);
  assign wr_period = wr_per_l || wr_per_h;
  assign wr_snap   = wr_en && ((reg_sel == REG_SNAP_L) || (reg_sel == REG_SNAP_H));
  assign start     = wr_ctrl && writedata[CTRL_START];

  assign cnt_step = (cnt == '0) ? period : cnt - COUNTER_W'(1);
  assign to_edge  = tick && (cnt == '0) && !zero_q;
  assign irq      = to && ctrl[CTRL_ITO];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= RESET_VAL;
      period      <= RESET_VAL;
      snap        <= '0;
      ctrl        <= '0;
      run         <= 1'b0;
      to          <= 1'b0;
      zero_q      <= 1'b1;
      reload_pend <= 1'b0;
    end else begin
      reload_pend <= wr_period;
      if (wr_per_l) period[15:0] <= writedata;
      if (wr_per_h) period[COUNTER_W-1:16] <= writedata[COUNTER_W-17:0];
      if (wr_ctrl)  ctrl <= writedata[3:0];
      if (wr_snap)  snap <= cnt;

      if (reload_pend)      cnt <= period;
      else if (run && tick) cnt <= cnt_step;

      if (wr_period)
        run <= 1'b0;
      else if (start)
        run <= 1'b1;
      else if (run && tick && !reload_pend && !ctrl[CTRL_CONT] && (cnt_step == '0))
        run <= 1'b0;

      // A zero period never leaves 0, so START re-arms the edge detector to
      // give exactly one timeout per start.
      if (start && (period == '0)) zero_q <= 1'b0;
      else if (reload_pend)        zero_q <= 1'b1;
      else if (tick)               zero_q <= (cnt == '0);

      if (wr_status)    to <= 1'b0;
      else if (to_edge) to <= 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_STATUS:   rd_data = {14'b0, run, to};
      REG_CONTROL:  rd_data = {12'b0, ctrl};
      REG_PERIOD_L: rd_data = period[15:0];
      REG_PERIOD_H: rd_data = 16'(period[COUNTER_W-1:16]);
      REG_SNAP_L:   rd_data = snap[15:0];
      REG_SNAP_H:   rd_data = 16'(snap[COUNTER_W-1:16]);
      default:      rd_data = '0;
    endcase
  end

endmodule

// File: rtl/alarm_timer_multi.sv
// Multi-channel interval timer with Avalon-MM slave: decode, tick source, read mux.
// Define ALARM_TIMER_PRESCALER_EN to advance counters every PRESCALE_DIV clocks.
module alarm_timer_multi
  import alarm_timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          COUNTER_W    = 32,
  parameter logic [31:0] RESET_PERIOD = 32'd49_999_999,
  parameter int          PRESCALE_DIV = 50
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [addr_w(NUM_CH)-1:0] address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [15:0]               writedata,
  output logic [15:0]               readdata,
  output logic [NUM_CH-1:0]         irq,
  output logic                      irq_any
);

  localparam int ADDR_W = addr_w(NUM_CH);

  logic [ADDR_W-1:0] ch_idx;
  logic [2:0]        reg_sel;
  logic              wr_req;
  logic              tick;
  logic [15:0]       ch_rd [NUM_CH];
  logic [15:0]       rd_mux;

  assign reg_sel = address[2:0];
  assign ch_idx  = address >> 3;
  assign wr_req  = chipselect && !write_n;
  assign irq_any = |irq;

`ifdef ALARM_TIMER_PRESCALER_EN
  localparam int PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  logic [PRE_W-1:0] pre_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               pre_cnt <= PRE_W'(PRESCALE_DIV - 1);
    else if (pre_cnt == '0)  pre_cnt <= PRE_W'(PRESCALE_DIV - 1);
    else                     pre_cnt <= pre_cnt - PRE_W'(1);
  end

  assign tick = (pre_cnt == '0);
`else
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    alarm_timer_channel #(
      .COUNTER_W (COUNTER_W),
      .RESET_VAL (RESET_PERIOD[COUNTER_W-1:0])
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .wr_en     (wr_req && (ch_idx == ADDR_W'(i))),
      .reg_sel   (reg_sel),
      .writedata (writedata),
      .rd_data   (ch_rd[i]),
      .irq       (irq[i])
    );
  end

  // PENDING is global, so it bypasses the channel select
  always_comb begin
    rd_mux = '0;
    if (reg_sel == REG_PENDING) begin
      rd_mux = 16'(irq);
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (ch_idx == ADDR_W'(i)) rd_mux = ch_rd[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

endmodule

// File: tb/tb_alarm_timer_multi.sv
// Self-checking bench for alarm_timer_multi (default build, 4 channels, 32-bit counters).
module tb_alarm_timer_multi;
  import alarm_timer_pkg::*;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [15:0]       writedata;
  logic [15:0]       readdata;
  logic [NUM_CH-1:0] irq;
  logic              irq_any;

  int n_tests = 0;
  int n_fail  = 0;

  alarm_timer_multi #(.NUM_CH(NUM_CH), .COUNTER_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_any    (irq_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    int          ch;
    logic [2:0]  r;
    logic [15:0] val;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit w, int ch, logic [2:0] r, logic [15:0] v, string n);
    vec_t e;
    e.is_wr = w; e.ch = ch; e.r = r; e.val = v; e.name = n;
    vecs.push_back(e);
  endfunction

  // Timer behaviour in closed form: k = clock edges since the START write edge.
  function automatic int unsigned ref_cnt(int unsigned p, bit cont, int unsigned k);
    if (cont) return p - (k % (p + 1));
    return (k >= p) ? 0 : p - k;
  endfunction

  function automatic bit ref_run(int unsigned p, bit cont, int unsigned k);
    return cont || (k < p);
  endfunction

  function automatic bit ref_to(int unsigned p, int unsigned k);
    return k >= p + 1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus tasks are entered and left just after a falling edge.
  task automatic wr(int ch, logic [2:0] r, logic [15:0] d);
    address = ADDR_W'(ch * 8) | ADDR_W'(r);
    writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(int ch, logic [2:0] r, output logic [15:0] d);
    address = ADDR_W'(ch * 8) | ADDR_W'(r);
    chipselect = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic program_ch(int ch, int unsigned p, logic [15:0] ctrl);
    wr(ch, REG_PERIOD_L, p[15:0]);
    wr(ch, REG_PERIOD_H, p[31:16]);
    wr(ch, REG_STATUS, 16'h0000);
    wr(ch, REG_CONTROL, ctrl);
  endtask

  task automatic wait_irq(int ch, int max, output int k);
    k = 0;
    while (k < max && !irq[ch]) begin
      @(negedge clk);
      k++;
    end
  endtask

  logic [15:0] v;
  int          k, k2;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    idle(3);
    reset = 1'b0;
    idle(1);

    check("rst_irq", 32'(irq), 32'h0);
    check("rst_irq_any", 32'(irq_any), 32'h0);

    add(0, 0, REG_STATUS,   16'h0000, "rst_status");
    add(0, 0, REG_CONTROL,  16'h0000, "rst_control");
    add(0, 0, REG_PERIOD_L, 16'hF07F, "rst_period_l");
    add(0, 0, REG_PERIOD_H, 16'h02FA, "rst_period_h");
    add(0, 0, REG_SNAP_L,   16'h0000, "rst_snap_l");
    add(0, 0, REG_SNAP_H,   16'h0000, "rst_snap_h");
    add(0, 2, REG_PENDING,  16'h0000, "rst_pending");
    add(0, 1, REG_RESERVED, 16'h0000, "rst_reserved");
    add(0, 3, REG_PERIOD_L, 16'hF07F, "rst_ch3_period_l");
    add(1, 2, REG_CONTROL,  16'h000A, "");
    add(0, 2, REG_CONTROL,  16'h000A, "ctrl_readback");
    add(0, 2, REG_STATUS,   16'h0000, "ctrl_no_start");
    add(1, 1, REG_RESERVED, 16'hFFFF, "");
    add(0, 1, REG_RESERVED, 16'h0000, "reserved_ignored");
    add(1, 3, REG_PERIOD_L, 16'h1234, "");
    add(1, 3, REG_PERIOD_H, 16'hABCD, "");
    add(0, 3, REG_PERIOD_L, 16'h1234, "period_l_readback");
    add(0, 3, REG_PERIOD_H, 16'hABCD, "period_h_readback");
    add(0, 3, REG_STATUS,   16'h0000, "period_wr_stopped");

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) wr(vecs[i].ch, vecs[i].r, vecs[i].val);
      else begin
        rd(vecs[i].ch, vecs[i].r, v);
        check(vecs[i].name, 32'(v), 32'(vecs[i].val));
      end
    end

    // one-shot ch1, period 5
    program_ch(1, 5, 16'h0005);
    wait_irq(1, 40, k);
    check("oneshot_to_delay", k, 6);
    rd(1, REG_STATUS, v);
    check("oneshot_status", 32'(v), 32'h0001);
    check("oneshot_irq_any", 32'(irq_any), 32'h1);
    rd(3, REG_PENDING, v);
    check("oneshot_pending", 32'(v), 32'h0002);
    wr(1, REG_STATUS, 16'h0000);
    check("oneshot_irq_cleared", 32'(irq), 32'h0);

    // continuous ch2, period 3
    program_ch(2, 3, 16'h0007);
    wait_irq(2, 40, k);
    check("cont_first_to", k, 4);
    wr(2, REG_STATUS, 16'h0000);
    wait_irq(2, 40, k2);
    check("cont_second_to", k + 1 + k2, 8);
    rd(2, REG_STATUS, v);
    check("cont_status", 32'(v), 32'h0003);
    wr(2, REG_PERIOD_L, 16'h0003);
    wr(2, REG_STATUS, 16'h0000);
    check("cont_stopped_irq_any", 32'(irq_any), 32'h0);

    // ch0 period 1000: snapshot at 700, then period write mid-count
    program_ch(0, 1000, 16'h0004);
    idle(300);
    wr(0, REG_SNAP_L, 16'h0000);
    rd(0, REG_SNAP_L, v);
    check("snap_l_700", 32'(v), 32'h02BC);
    rd(0, REG_SNAP_H, v);
    check("snap_h_700", 32'(v), 32'h0000);
    wr(0, REG_PERIOD_L, 16'h0010);
    rd(0, REG_STATUS, v);
    check("period_wr_stops_run", 32'(v), 32'h0000);
    wr(0, REG_SNAP_L, 16'h0000);
    rd(0, REG_SNAP_L, v);
    check("period_wr_reload", 32'(v), 32'h0010);

    // START+STOP together starts
    wr(3, REG_CONTROL, 16'h000C);
    rd(3, REG_STATUS, v);
    check("start_stop_runs", 32'(v), 32'h0002);

    // STATUS write on the exact timeout-edge cycle
    program_ch(3, 2, 16'h0005);
    idle(2);
    wr(3, REG_STATUS, 16'h0000);
    rd(3, REG_STATUS, v);
    check("clear_wins_status", 32'(v), 32'h0000);
    check("clear_wins_irq", 32'(irq[3]), 32'h0);
    idle(4);
    check("held_zero_no_retrigger", 32'(irq[3]), 32'h0);

    // period 0: one timeout per START
    program_ch(0, 0, 16'h0007);
    wait_irq(0, 20, k);
    check("p0_first_to", k, 1);
    wr(0, REG_STATUS, 16'h0000);
    idle(8);
    check("p0_once_only", 32'(irq[0]), 32'h0);
    rd(0, REG_STATUS, v);
    check("p0_cont_running", 32'(v), 32'h0002);
    wr(0, REG_CONTROL, 16'h0007);
    wait_irq(0, 20, k);
    check("p0_restart_to", k, 1);
    wr(0, REG_PERIOD_L, 16'h0001);
    wr(0, REG_STATUS, 16'h0000);

    // randomized trials against the closed-form model
    for (int t = 0; t < 40; t++) begin
      int          ch;
      int unsigned p, d, kk;
      bit          cont, ito;
      ch   = $urandom_range(0, NUM_CH - 1);
      p    = $urandom_range(1, 12);
      cont = 1'($urandom_range(0, 1));
      ito  = 1'($urandom_range(0, 1));
      d    = $urandom_range(0, 3 * p + 3);
      program_ch(ch, p, {12'b0, 1'b0, 1'b1, cont, ito});
      idle(int'(d));
      wr(ch, REG_SNAP_L, 16'h0000);
      rd(ch, REG_SNAP_L, v);
      check("rnd_snap", 32'(v), ref_cnt(p, cont, d));
      kk = d + 2;
      check("rnd_irq", 32'(irq[ch]), 32'(ref_to(p, kk) && ito));
      rd(ch, REG_STATUS, v);
      check("rnd_status", 32'(v), 32'({ref_run(p, cont, kk), ref_to(p, kk)}));
    end

    // asynchronous reset while counting
    program_ch(1, 4, 16'h0007);
    idle(10);
    check("pre_reset_irq", 32'(irq[1]), 32'h1);
    #2 reset = 1'b1;
    #1 check("async_reset_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd(1, REG_PERIOD_L, v);
    check("post_reset_period_l", 32'(v), 32'hF07F);
    rd(1, REG_STATUS, v);
    check("post_reset_status", 32'(v), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
